// File: rtl/hamming26_scrub_regfile.sv
// ECC-protected register file: 26-bit entries stored as 32-bit SEC-DED Hamming words,
// with read-path correction/write-back, a background scrubber, error counters and a DED interrupt.
module hamming26_scrub_regfile #(
   parameter int DEPTH        = 8,
   parameter int SCRUB_PERIOD = 1024,
   parameter int CNT_W        = 16,
   localparam int AW          = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [25:0]      wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [25:0]      rdata_o,
   output logic             rvalid_o,
   output logic             rded_o,
   input  logic             scrub_en_i,
   input  logic             inj_en_i,
   input  logic [AW-1:0]    inj_addr_i,
   input  logic [31:0]      inj_mask_i,
   input  logic             cnt_clr_i,
   output logic [CNT_W-1:0] sec_cnt_o,
   output logic [CNT_W-1:0] ded_cnt_o,
   output logic             err_irq_o
);

   localparam int TW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;

   typedef struct packed {
      logic        ded;
      logic        sec;
      logic [25:0] data;
   } dec_t;

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WB} state_t;

   // Bit 0 is overall parity, powers of two are Hamming parity, the rest carry data LSB-first.
   function automatic logic [31:0] hamming32t26d_enc(input logic [25:0] d);
      logic [31:0] v;
      logic [4:0]  syn;
      logic        is_data;
      int          k;
      v   = 32'd0;
      syn = 5'd0;
      k   = 0;
      for (int p = 3; p < 32; p++) begin
         is_data   = ((p & (p - 1)) != 0);
         v[p[4:0]] = is_data ? d[k[4:0]] : 1'b0;
         syn       = syn ^ ((is_data && d[k[4:0]]) ? p[4:0] : 5'd0);
         k         = k + (is_data ? 1 : 0);
      end
      v[1]  = syn[0];
      v[2]  = syn[1];
      v[4]  = syn[2];
      v[8]  = syn[3];
      v[16] = syn[4];
      v[0]  = ^v[31:1];
      return v;
   endfunction

   // A zero syndrome with odd parity points at bit 0, so parity-only errors count as SEC.
   function automatic dec_t hamming32t26d_dec(input logic [31:0] v);
      dec_t        r;
      logic [4:0]  syn;
      logic [31:0] c;
      logic        is_data;
      int          k;
      syn = 5'd0;
      for (int p = 1; p < 32; p++) begin
         syn = syn ^ (v[p[4:0]] ? p[4:0] : 5'd0);
      end
      r.sec  = ^v;
      r.ded  = !r.sec && (syn != 5'd0);
      c      = v ^ (r.sec ? (32'd1 << syn) : 32'd0);
      r.data = 26'd0;
      k      = 0;
      for (int p = 3; p < 32; p++) begin
         is_data            = ((p & (p - 1)) != 0);
         r.data[k[4:0]]     = is_data ? c[p[4:0]] : r.data[k[4:0]];
         k                  = k + (is_data ? 1 : 0);
      end
      return r;
   endfunction

   logic [31:0]      mem_r     [DEPTH];
   logic [31:0]      mem_nxt_s [DEPTH];
   state_t           state_r;
   logic [AW-1:0]    ptr_r;
   logic [TW-1:0]    timer_r;
   logic [25:0]      sc_data_r;
   logic             sc_wb_r;
   logic [25:0]      rdata_r;
   logic             rvalid_r;
   logic             rded_r;
   logic [CNT_W-1:0] sec_cnt_r;
   logic [CNT_W-1:0] ded_cnt_r;
   logic             err_irq_r;

   dec_t             rd_dec_s;
   dec_t             sc_dec_s;
   logic [31:0]      wr_word_s;
   logic [31:0]      rd_wb_word_s;
   logic [31:0]      sc_wb_word_s;
   logic             rd_wb_s;
   logic             sc_wb_s;
   logic             check_s;
   logic             ptr_hit_s;
   logic             sec_hit_s;
   logic             ded_hit_s;

   // Decode both ports and derive write-back requests and detection events.
   always_comb begin
      rd_dec_s     = hamming32t26d_dec(mem_r[raddr_i]);
      sc_dec_s     = hamming32t26d_dec(mem_r[ptr_r]);
      wr_word_s    = hamming32t26d_enc(wdata_i);
      rd_wb_word_s = hamming32t26d_enc(rd_dec_s.data);
      sc_wb_word_s = hamming32t26d_enc(sc_data_r);
      rd_wb_s      = re_i && rd_dec_s.sec;
      check_s      = (state_r == S_CHECK) && !re_i;
      sc_wb_s      = (state_r == S_WB) && sc_wb_r;
      ptr_hit_s    = (we_i && (waddr_i == ptr_r)) || (inj_en_i && (inj_addr_i == ptr_r));
      if (re_i) begin
         sec_hit_s = rd_dec_s.sec;
         ded_hit_s = rd_dec_s.ded;
      end else begin
         sec_hit_s = check_s && sc_dec_s.sec;
         ded_hit_s = check_s && sc_dec_s.ded;
      end
   end

   // Per-entry update priority: write, injection, read write-back, scrub write-back.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (we_i && (waddr_i == AW'(i))) begin
            mem_nxt_s[i] = wr_word_s;
         end else if (inj_en_i && (inj_addr_i == AW'(i))) begin
            mem_nxt_s[i] = mem_r[i] ^ inj_mask_i;
         end else if (rd_wb_s && (raddr_i == AW'(i))) begin
            mem_nxt_s[i] = rd_wb_word_s;
         end else if (sc_wb_s && (ptr_r == AW'(i))) begin
            mem_nxt_s[i] = sc_wb_word_s;
         end else begin
            mem_nxt_s[i] = mem_r[i];
         end
      end
   end

   // Storage array.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 32'd0;
         end
      end else begin
         mem_r <= mem_nxt_s;
      end
   end

   // Scrubber FSM.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_r   <= S_IDLE;
         ptr_r     <= {AW{1'b0}};
         timer_r   <= {TW{1'b0}};
         sc_data_r <= 26'd0;
         sc_wb_r   <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (!scrub_en_i) begin
                  timer_r <= {TW{1'b0}};
               end else if (timer_r == TW'(SCRUB_PERIOD - 1)) begin
                  timer_r <= {TW{1'b0}};
                  state_r <= S_CHECK;
               end else begin
                  timer_r <= timer_r + TW'(1);
               end
            end
            S_CHECK: begin
               if (!re_i) begin
                  sc_data_r <= sc_dec_s.data;
                  // A write or injection landing now would be overwritten by a stale correction.
                  sc_wb_r   <= sc_dec_s.sec && !ptr_hit_s;
                  state_r   <= S_WB;
               end
            end
            S_WB: begin
               ptr_r   <= ptr_r + AW'(1);
               state_r <= S_IDLE;
            end
            default: state_r <= S_IDLE;
         endcase
      end
   end

   // Registered read response, saturating counters and DED interrupt.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rdata_r   <= 26'd0;
         rvalid_r  <= 1'b0;
         rded_r    <= 1'b0;
         sec_cnt_r <= {CNT_W{1'b0}};
         ded_cnt_r <= {CNT_W{1'b0}};
         err_irq_r <= 1'b0;
      end else begin
         rvalid_r  <= re_i;
         err_irq_r <= ded_hit_s;
         if (re_i) begin
            rdata_r <= rd_dec_s.data;
            rded_r  <= rd_dec_s.ded;
         end
         if (cnt_clr_i) begin
            sec_cnt_r <= {CNT_W{1'b0}};
            ded_cnt_r <= {CNT_W{1'b0}};
         end else begin
            if (sec_hit_s && (sec_cnt_r != {CNT_W{1'b1}})) begin
               sec_cnt_r <= sec_cnt_r + CNT_W'(1);
            end
            if (ded_hit_s && (ded_cnt_r != {CNT_W{1'b1}})) begin
               ded_cnt_r <= ded_cnt_r + CNT_W'(1);
            end
         end
      end
   end

   assign rdata_o   = rdata_r;
   assign rvalid_o  = rvalid_r;
   assign rded_o    = rded_r;
   assign sec_cnt_o = sec_cnt_r;
   assign ded_cnt_o = ded_cnt_r;
   assign err_irq_o = err_irq_r;

endmodule

// File: tb/tb_hamming26_scrub_regfile.sv
// Scoreboard bench for hamming26_scrub_regfile: reads push expectations, a negedge monitor pops them.
module tb_hamming26_scrub_regfile;

   localparam int AW = 3;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rstn;
   logic          we, re, scrub_en, inj_en, cnt_clr;
   logic [AW-1:0] waddr, raddr, inj_addr;
   logic [25:0]   wdata, rdata;
   logic [31:0]   inj_mask;
   logic          rvalid, rded, err_irq;
   logic [CW-1:0] sec_cnt, ded_cnt;

   typedef struct packed {
      logic [25:0] data;
      logic        ded;
      logic        chk;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   bit   done;

   always #5 clk = ~clk;

   hamming26_scrub_regfile #(.DEPTH(8), .SCRUB_PERIOD(4), .CNT_W(CW)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .re_i(re), .raddr_i(raddr), .rdata_o(rdata), .rvalid_o(rvalid), .rded_o(rded),
      .scrub_en_i(scrub_en),
      .inj_en_i(inj_en), .inj_addr_i(inj_addr), .inj_mask_i(inj_mask),
      .cnt_clr_i(cnt_clr),
      .sec_cnt_o(sec_cnt), .ded_cnt_o(ded_cnt), .err_irq_o(err_irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every read response is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rstn && rvalid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_rvalid", {31'd0, rvalid}, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk) check("rdata", {6'd0, rdata}, {6'd0, mon_e.data});
            check("rded", {31'd0, rded}, {31'd0, mon_e.ded});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [25:0] d);
      we = 1'b1; waddr = a; wdata = d;
      tick();
      we = 1'b0;
   endtask

   task automatic inj(input logic [AW-1:0] a, input logic [31:0] m);
      inj_en = 1'b1; inj_addr = a; inj_mask = m;
      tick();
      inj_en = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [25:0] d, input logic ded, input logic chk);
      re = 1'b1; raddr = a;
      sb_q.push_back('{data: d, ded: ded, chk: chk});
      tick();
      re = 1'b0;
   endtask

   task automatic clr();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
   endtask

   task automatic wait_sec(input int limit, input logic [CW-1:0] target, input string name);
      done = 1'b0;
      for (int i = 0; i < limit && !done; i++) begin
         tick();
         if (sec_cnt == target) done = 1'b1;
      end
      check(name, {30'd0, sec_cnt}, {30'd0, target});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0; we = 1'b0; re = 1'b0; scrub_en = 1'b0; inj_en = 1'b0; cnt_clr = 1'b0;
      waddr = 3'd0; raddr = 3'd0; inj_addr = 3'd0; wdata = 26'd0; inj_mask = 32'd0;
      repeat (3) tick();
      check("rst_rdata", {6'd0, rdata}, 32'd0);
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_sec_cnt", {30'd0, sec_cnt}, 32'd0);
      check("rst_ded_cnt", {30'd0, ded_cnt}, 32'd0);
      check("rst_irq", {31'd0, err_irq}, 32'd0);
      rstn = 1'b1;
      tick();

      rd(3'd0, 26'd0, 1'b0, 1'b1);
      tick();
      check("rd0_sec_cnt", {30'd0, sec_cnt}, 32'd0);
      check("rd0_ded_cnt", {30'd0, ded_cnt}, 32'd0);

      // Single-bit error on a Hamming parity position.
      wr(3'd3, 26'h2AAAAAA);
      inj(3'd3, 32'h0000_0010);
      rd(3'd3, 26'h2AAAAAA, 1'b0, 1'b1);
      check("sec_cnt_after_sec_read", {30'd0, sec_cnt}, 32'd1);
      check("no_irq_on_sec", {31'd0, err_irq}, 32'd0);
      tick();
      check("rdata_hold", {6'd0, rdata}, 32'h2AAAAAA);
      check("rvalid_pulse", {31'd0, rvalid}, 32'd0);
      rd(3'd3, 26'h2AAAAAA, 1'b0, 1'b1);
      check("sec_cnt_after_writeback", {30'd0, sec_cnt}, 32'd1);

      // Double-bit error.
      clr();
      inj(3'd5, 32'h0000_0018);
      rd(3'd5, 26'd0, 1'b1, 1'b0);
      check("irq_on_ded", {31'd0, err_irq}, 32'd1);
      check("ded_cnt_1", {30'd0, ded_cnt}, 32'd1);
      tick();
      check("irq_single_pulse", {31'd0, err_irq}, 32'd0);
      rd(3'd5, 26'd0, 1'b1, 1'b0);
      check("ded_word_unchanged", {30'd0, ded_cnt}, 32'd2);

      // Read and write to the same address in one cycle returns old data.
      wr(3'd2, 26'h1234567);
      we = 1'b1; waddr = 3'd2; wdata = 26'h0ABCDEF;
      re = 1'b1; raddr = 3'd2;
      sb_q.push_back('{data: 26'h1234567, ded: 1'b0, chk: 1'b1});
      tick();
      we = 1'b0; re = 1'b0;
      rd(3'd2, 26'h0ABCDEF, 1'b0, 1'b1);
      check("rw_same_cycle_no_count", {30'd0, sec_cnt}, 32'd0);

      // Back-to-back reads.
      re = 1'b1;
      raddr = 3'd3; sb_q.push_back('{data: 26'h2AAAAAA, ded: 1'b0, chk: 1'b1}); tick();
      raddr = 3'd2; sb_q.push_back('{data: 26'h0ABCDEF, ded: 1'b0, chk: 1'b1}); tick();
      raddr = 3'd0; sb_q.push_back('{data: 26'd0,       ded: 1'b0, chk: 1'b1}); tick();
      re = 1'b0;

      // Counter saturation with a 2-bit counter, then clear against a detection.
      clr();
      re = 1'b1; raddr = 3'd5;
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back('{data: 26'd0, ded: 1'b1, chk: 1'b0});
         tick();
      end
      re = 1'b0;
      check("ded_cnt_saturated", {30'd0, ded_cnt}, 32'd3);
      tick();
      check("ded_cnt_stays_sat", {30'd0, ded_cnt}, 32'd3);
      cnt_clr = 1'b1; re = 1'b1; raddr = 3'd5;
      sb_q.push_back('{data: 26'd0, ded: 1'b1, chk: 1'b0});
      tick();
      cnt_clr = 1'b0; re = 1'b0;
      check("clr_beats_increment", {30'd0, ded_cnt}, 32'd0);
      check("irq_with_clr", {31'd0, err_irq}, 32'd1);

      // Scrubber repairs entry 7, then wraps to entry 0.
      wr(3'd5, 26'h0000055);
      clr();
      inj(3'd7, 32'h0000_0100);
      scrub_en = 1'b1;
      wait_sec(50, 2'd1, "scrub_sec_entry7");
      check("scrub_no_ded", {30'd0, ded_cnt}, 32'd0);
      inj(3'd0, 32'h0000_0001);
      wait_sec(12, 2'd2, "scrub_wrap_entry0");
      scrub_en = 1'b0;
      tick();
      rd(3'd7, 26'd0, 1'b0, 1'b1);
      rd(3'd0, 26'd0, 1'b0, 1'b1);
      check("scrub_writeback_done", {30'd0, sec_cnt}, 32'd2);

      // Continuous reads stall the scrubber in CHECK on entry 1.
      inj(3'd1, 32'h8000_0000);
      clr();
      scrub_en = 1'b1;
      re = 1'b1; raddr = 3'd2;
      for (int i = 0; i < 20; i++) begin
         sb_q.push_back('{data: 26'h0ABCDEF, ded: 1'b0, chk: 1'b1});
         tick();
         check("stall_no_count", {30'd0, sec_cnt}, 32'd0);
      end
      re = 1'b0;
      wait_sec(10, 2'd1, "scrub_after_stall");
      scrub_en = 1'b0;
      tick();
      rd(3'd1, 26'd0, 1'b0, 1'b1);
      check("stall_writeback_done", {30'd0, sec_cnt}, 32'd1);

      // Mid-operation reset clears counters, read data and storage.
      inj(3'd3, 32'h0000_0010);
      rd(3'd3, 26'h2AAAAAA, 1'b0, 1'b1);
      tick();
      check("pre_reset_sec_cnt", {30'd0, sec_cnt}, 32'd2);
      rstn = 1'b0;
      #2;
      check("midrst_sec_cnt", {30'd0, sec_cnt}, 32'd0);
      check("midrst_rdata", {6'd0, rdata}, 32'd0);
      tick();
      rstn = 1'b1;
      tick();
      rd(3'd3, 26'd0, 1'b0, 1'b1);
      repeat (2) tick();
      check("scoreboard_drained", sb_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
